// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL lock source and the reset sequencer.
// The master side drives lock/soft-request; the slave side returns reset and status.
interface pll_reset_sequencer_if;
    logic       locked;
    logic       soft_req;
    logic       out_reset;
    logic       ready;
    logic [7:0] loss_count;
    logic [1:0] state;

    modport master (
        output locked,
        output soft_req,
        input  out_reset,
        input  ready,
        input  loss_count,
        input  state
    );

    modport slave (
        input  locked,
        input  soft_req,
        output out_reset,
        output ready,
        output loss_count,
        output state
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Turns the asynchronous PLL lock flag into a clean synchronous design reset
// that releases after a stability window plus a hold interval; counts lock losses.
module pll_reset_sequencer #(
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES   = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    pll_reset_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);

    logic        sync1, lock_s;
    state_t      cur, nxt;
    logic [15:0] count, count_nxt;
    logic        out_reset_q, ready_q, out_reset_nxt;
    logic [7:0]  loss_q, loss_nxt;

    // Two-flop synchronizer; lock_s is the only consumer of locked.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync1  <= bus.locked;
            lock_s <= sync1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur         <= WAIT_LOCK;
            count       <= 16'd0;
            out_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            loss_q      <= 8'd0;
        end else begin
            cur         <= nxt;
            count       <= count_nxt;
            out_reset_q <= out_reset_nxt;
            ready_q     <= ~out_reset_nxt;
            loss_q      <= loss_nxt;
        end
    end

    // Lock loss is checked first in every state so it beats soft_req and terminal counts.
    always_comb begin
        nxt = cur;
        case (cur)
            WAIT_LOCK: if (lock_s) nxt = STABILIZE;
            STABILIZE: begin
                if (!lock_s)                  nxt = WAIT_LOCK;
                else if (count == STABLE_LAST) nxt = HOLD;
            end
            HOLD: begin
                if (!lock_s)                nxt = WAIT_LOCK;
                else if (count == HOLD_LAST) nxt = RUN;
            end
            RUN: begin
                if (!lock_s)          nxt = WAIT_LOCK;
                else if (bus.soft_req) nxt = HOLD;
            end
            default: nxt = WAIT_LOCK;
        endcase
    end

    // Outputs are computed from the next state so the registered values line up
    // with the state register rather than trailing it by a cycle.
    always_comb begin
        count_nxt = 16'd0;
        if (nxt == cur && (cur == STABILIZE || cur == HOLD))
            count_nxt = 16'(count + 16'd1);

        out_reset_nxt = (nxt != RUN);

        loss_nxt = loss_q;
        if (cur == RUN && !lock_s && loss_q != 8'hFF)
            loss_nxt = 8'(loss_q + 8'd1);
    end

    assign bus.state      = cur;
    assign bus.out_reset  = out_reset_q;
    assign bus.ready      = ready_q;
    assign bus.loss_count = loss_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench: stimulus queues the expected output transitions with their edge
// numbers; a monitor compares each observed output change against the queue head.
module tb_pll_reset_sequencer;
    localparam int S = 8;
    localparam int H = 4;

    logic clock = 1'b0;
    logic reset_n;
    int   edge_n = 0;

    pll_reset_sequencer_if bus();

    pll_reset_sequencer #(.STABLE_CYCLES(S), .HOLD_CYCLES(H)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) edge_n <= edge_n + 1;

    typedef struct {
        int         e;     // expected edge number, -1 = any
        logic [1:0] st;
        logic       rst;
        logic       rdy;
        logic [7:0] lc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [11:0] snap();
        return {bus.state, bus.out_reset, bus.ready, bus.loss_count};
    endfunction

    task automatic push_exp(input int e, input logic [1:0] st, input logic rst, input logic [7:0] lc);
        exp_t x;
        x.e = e; x.st = st; x.rst = rst; x.rdy = ~rst; x.lc = lc;
        q.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic until_edge(input int e);
        while (edge_n < e) step(1);
    endtask

    task automatic check_now(input string nm, input logic [11:0] got, input logic [11:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got st=%0d rst=%0b rdy=%0b lc=%0d, want st=%0d rst=%0b rdy=%0b lc=%0d",
                     nm, got[11:10], got[9], got[8], got[7:0], want[11:10], want[9], want[8], want[7:0]);
        end
    endtask

    task automatic monitor();
        logic [11:0] prev;
        logic [11:0] cur;
        exp_t x;
        prev = {2'd0, 1'b1, 1'b0, 8'd0};
        forever begin
            @(negedge clock);
            cur = snap();
            if (cur !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change at edge %0d: got st=%0d rst=%0b rdy=%0b lc=%0d, want no change",
                             edge_n, cur[11:10], cur[9], cur[8], cur[7:0]);
                end else begin
                    x = q.pop_front();
                    if (cur !== {x.st, x.rst, x.rdy, x.lc} || (x.e >= 0 && x.e != edge_n)) begin
                        errors++;
                        $display("FAIL seq_change: got edge %0d st=%0d rst=%0b rdy=%0b lc=%0d, want edge %0d st=%0d rst=%0b rdy=%0b lc=%0d",
                                 edge_n, cur[11:10], cur[9], cur[8], cur[7:0], x.e, x.st, x.rst, x.rdy, x.lc);
                    end
                end
                prev = cur;
            end
        end
    endtask

    initial begin
        int e;
        int lc;
        reset_n      = 1'b0;
        bus.locked   = 1'b0;
        bus.soft_req = 1'b0;
        fork
            monitor();
        join_none

        step(3);
        check_now("reset_state", snap(), {2'd0, 1'b1, 1'b0, 8'd0});
        reset_n = 1'b1;
        step(2);

        // Lock, then drop for 3 cycles while STABILIZE counter reads 5
        e = edge_n;
        bus.locked = 1'b1;
        push_exp(e + 3, 2'd1, 1'b1, 8'd0);
        push_exp(e + 9, 2'd0, 1'b1, 8'd0);
        until_edge(e + 6);
        bus.locked = 1'b0;
        until_edge(e + 9);
        bus.locked = 1'b1;
        e = edge_n;
        push_exp(e + 3,  2'd1, 1'b1, 8'd0);
        push_exp(e + 11, 2'd2, 1'b1, 8'd0);
        push_exp(e + 15, 2'd3, 1'b0, 8'd0);
        until_edge(e + 17);

        // Sub-cycle glitch between edges is invisible
        #1 bus.locked = 1'b0;
        #1 bus.locked = 1'b1;
        step(3);

        // Soft re-issue from RUN; a second pulse during HOLD must not restart the count
        e = edge_n;
        bus.soft_req = 1'b1;
        push_exp(e + 1, 2'd2, 1'b1, 8'd0);
        push_exp(e + 5, 2'd3, 1'b0, 8'd0);
        step(1);
        bus.soft_req = 1'b0;
        step(1);
        bus.soft_req = 1'b1;
        step(1);
        bus.soft_req = 1'b0;
        until_edge(e + 8);

        // Lock loss in RUN; soft_req in WAIT_LOCK ignored; full relock
        lc = 0;
        e = edge_n;
        bus.locked = 1'b0;
        lc = 1;
        push_exp(e + 3, 2'd0, 1'b1, 8'(lc));
        until_edge(e + 4);
        bus.soft_req = 1'b1;
        step(1);
        bus.soft_req = 1'b0;
        until_edge(e + 6);
        bus.locked = 1'b1;
        e = edge_n;
        push_exp(e + 3,  2'd1, 1'b1, 8'(lc));
        push_exp(e + 11, 2'd2, 1'b1, 8'(lc));
        push_exp(e + 15, 2'd3, 1'b0, 8'(lc));
        until_edge(e + 17);

        // soft_req and lock loss seen on the same decision edge: loss wins
        e = edge_n;
        bus.locked = 1'b0;
        lc = 2;
        push_exp(e + 3, 2'd0, 1'b1, 8'(lc));
        until_edge(e + 2);
        bus.soft_req = 1'b1;
        step(1);
        bus.soft_req = 1'b0;
        until_edge(e + 4);
        bus.locked = 1'b1;
        e = edge_n;
        push_exp(e + 3,  2'd1, 1'b1, 8'(lc));
        push_exp(e + 11, 2'd2, 1'b1, 8'(lc));
        push_exp(e + 15, 2'd3, 1'b0, 8'(lc));
        until_edge(e + 15);

        // 300 further losses: counter saturates at 255
        for (int i = 0; i < 300; i++) begin
            e = edge_n;
            bus.locked = 1'b0;
            lc = (lc < 255) ? lc + 1 : 255;
            push_exp(e + 3, 2'd0, 1'b1, 8'(lc));
            until_edge(e + 3);
            bus.locked = 1'b1;
            e = edge_n;
            push_exp(e + 3,  2'd1, 1'b1, 8'(lc));
            push_exp(e + 11, 2'd2, 1'b1, 8'(lc));
            if (i < 299) begin
                push_exp(e + 15, 2'd3, 1'b0, 8'(lc));
                until_edge(e + 15);
            end
        end
        check_now("loss_saturated", {2'd0, 1'b1, 1'b0, bus.loss_count}, {2'd0, 1'b1, 1'b0, 8'd255});

        // Asynchronous reset while in HOLD, checked before any clock edge
        until_edge(e + 12);
        push_exp(-1, 2'd0, 1'b1, 8'd0);
        #1 reset_n = 1'b0;
        #1 check_now("async_reset_in_hold", snap(), {2'd0, 1'b1, 1'b0, 8'd0});
        step(2);
        reset_n = 1'b1;
        step(3);

        while (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_change: got none, want edge %0d st=%0d rst=%0b lc=%0d", x.e, x.st, x.rst, x.lc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Consumer end of the PLL lock interface. It runs in the PLL output clock domain and takes the asynchronous `locked` flag from the SB_PLL40 wrapper. It produces a clean, synchronous, active-high design reset that releases only after lock has been stable and a hold interval has elapsed. It also counts lock-loss events and accepts a soft re-sequence request.

Parameters:
STABLE_CYCLES, 1024, number of consecutive synchronized-lock cycles required before hold starts; legal range 1..65535.
HOLD_CYCLES, 16, number of cycles out_reset stays asserted after stability is reached; legal range 1..65535.

Ports:
clock  input  1  PLL output clock (PLLOUTCORE); the only clock.
reset_n  input  1  asynchronous, active-low reset; clears all state.
locked  input  1  PLL LOCK, asynchronous to clock.
soft_req  input  1  synchronous single-cycle pulse requesting a reset re-issue.
out_reset  output  1  active-high synchronous reset for downstream logic.
ready  output  1  high only in RUN; equals ~out_reset.
loss_count  output  8  saturating count of lock losses seen while in RUN.
state  output  2  debug: 0=WAIT_LOCK, 1=STABILIZE, 2=HOLD, 3=RUN.

Behaviour:
- Synchronizer: locked passes through 2 flops, both reset to 0. The second flop output is lock_s. No other logic samples locked directly.
- Counter: single 16-bit cycle counter shared by STABILIZE and HOLD. It is cleared on every state entry.
- Reset (reset_n=0, async):
  - state=WAIT_LOCK, counter=0, sync flops=0.
  - out_reset=1, ready=0, loss_count=0.
- All outputs are registered.
  - out_reset=1 in every state except RUN.
  - ready is its complement.
- WAIT_LOCK:
  - lock_s=1 -> STABILIZE.
  - soft_req is ignored.
- STABILIZE:
  - counter increments each cycle.
  - lock_s=0 -> WAIT_LOCK; not counted as a loss.
  - counter==STABLE_CYCLES-1 with lock_s=1 -> HOLD.
- HOLD:
  - counter increments each cycle.
  - lock_s=0 -> WAIT_LOCK.
  - counter==HOLD_CYCLES-1 -> RUN.
- RUN:
  - lock_s=0 -> WAIT_LOCK, and loss_count increments, saturating at 255.
  - Otherwise soft_req=1 -> HOLD with counter cleared; the stability wait is not repeated.
- Priority: lock loss beats soft_req in the same cycle. soft_req in STABILIZE or HOLD is ignored; the counter is not restarted.
- Release latency, counting from the first rising edge that samples locked=1:
  - out_reset falls on edge 3+STABLE_CYCLES+HOLD_CYCLES.
  - With defaults this is edge 1043.
- Assertion latency: out_reset rises on the 3rd edge after locked falls while in RUN (2 sync + 1 state).
- Soft re-issue:
  - out_reset rises on the edge after soft_req is sampled.
  - out_reset falls HOLD_CYCLES edges later.
- Glitch rule: a locked drop shorter than one clock period, not captured by the synchronizer, has no effect.
- reset_n asserted mid-sequence: immediate asynchronous return to the reset values. loss_count is cleared.

Test Plan:
- STABLE=8, HOLD=4; reset_n released, locked=1 from cycle 0 -> out_reset=1 through edge 14, falls at edge 15; ready=1 at edge 15; state sequence 0,1,2,3.
- Same params; locked drops for 3 cycles during STABILIZE (counter=5) -> state returns to 0; full 8+4 sequence restarts after relock; loss_count stays 0.
- In RUN, locked falls -> out_reset=1 on 3rd edge; loss_count 0->1; relock -> release after a further 3+8+4 edges.
- In RUN, pulse soft_req -> out_reset=1 next edge for exactly 4 cycles; state goes 3->2->3; loss_count unchanged.
- soft_req and locked fall in the same cycle while in RUN -> state ends in WAIT_LOCK (not HOLD); loss_count increments.
- 300 lock-loss events -> loss_count saturates at 255. Assert reset_n=0 in HOLD -> out_reset=1, loss_count=0, state=0 immediately, with no clock edge.
